// File: rtl/ir_presence_tracker.sv
// ir_presence_tracker: dwell-qualified presence FSM with enter/leave events, saturating count, dwell time and stuck alarm
module ir_presence_tracker #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DWELL_MS = 20,
    parameter int MAX_DWELL_MS = 5000,
    parameter int CNT_W        = 16,
    parameter int DWELL_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               object_i,
    input  logic               clear_i,
    output logic               enter_o,
    output logic               leave_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [DWELL_W-1:0] dwell_ms_o,
    output logic               dwell_valid_o,
    output logic               stuck_o,
    output logic [1:0]         state_o
);
    localparam int P_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] IDLE = 2'd0, QUAL = 2'd1, PRESENT = 2'd2, STUCK = 2'd3;
    localparam logic [P_W-1:0] P_LAST = P_W'(TICK_DIV - 1);
    localparam logic [DWELL_W-1:0] D_MIN = DWELL_W'(MIN_DWELL_MS);
    localparam logic [DWELL_W-1:0] D_MAX = DWELL_W'(MAX_DWELL_MS);
    logic [1:0]         state, state_nx;
    logic [P_W-1:0]     presc;
    logic [DWELL_W-1:0] d;
    logic               enter_nx, leave_nx, timing;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    // a falling object_i always beats a threshold reached in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = object_i ? QUAL : IDLE;
            QUAL:    state_nx = !object_i ? IDLE : (d == D_MIN) ? PRESENT : QUAL;
            PRESENT: state_nx = !object_i ? IDLE : (d == D_MAX) ? STUCK : PRESENT;
            default: state_nx = object_i ? STUCK : IDLE;
        endcase
    end
    always_comb begin
        enter_nx = state == QUAL && state_nx == PRESENT;
        leave_nx = (state == PRESENT || state == STUCK) && state_nx == IDLE;
        timing   = state == QUAL || state == PRESENT;
    end
    // idle keeps the ms timebase cleared so every qualification starts from zero
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            presc         <= '0;
            d             <= '0;
            count_o       <= '0;
            dwell_ms_o    <= '0;
            enter_o       <= 1'b0;
            leave_o       <= 1'b0;
            dwell_valid_o <= 1'b0;
            stuck_o       <= 1'b0;
        end else begin
            enter_o       <= enter_nx;
            leave_o       <= leave_nx;
            dwell_valid_o <= leave_nx;
            stuck_o       <= state_nx == STUCK;
            if (state == IDLE) begin
                presc <= '0;
                d     <= '0;
            end else if (timing) begin
                presc <= presc == P_LAST ? '0 : presc + 1'b1;
                if (presc == P_LAST && d != D_MAX) d <= d + 1'b1;
            end
            if (leave_nx) dwell_ms_o <= state == STUCK ? D_MAX : d;
            count_o <= clear_i ? '0 : (enter_nx && !(&count_o)) ? count_o + 1'b1 : count_o;
        end
    assign state_o = state;
endmodule

// File: tb/tb_ir_presence_tracker.sv
// tb_ir_presence_tracker: directed stimulus with an event scoreboard checked by a separate monitor
module tb_ir_presence_tracker;
    localparam int TICK_DIV = 4, MIN_DWELL_MS = 3, MAX_DWELL_MS = 10, CNT_W = 2, DWELL_W = 16;
    localparam int ENTER_LAT = 13;
    logic               clk = 1'b0, rst, object_i, clear_i;
    logic               enter_o, leave_o, dwell_valid_o, stuck_o;
    logic [CNT_W-1:0]   count_o;
    logic [DWELL_W-1:0] dwell_ms_o;
    logic [1:0]         state_o;
    typedef struct {
        bit enter;
        int cyc;
        int cnt;
        int dwell;
    } ev_t;
    ev_t sb[$];
    int  cyc = 0, checks = 0, fails = 0;
    ir_presence_tracker #(
        .TICK_DIV(TICK_DIV), .MIN_DWELL_MS(MIN_DWELL_MS), .MAX_DWELL_MS(MAX_DWELL_MS),
        .CNT_W(CNT_W), .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk), .rst(rst), .object_i(object_i), .clear_i(clear_i),
        .enter_o(enter_o), .leave_o(leave_o), .count_o(count_o), .dwell_ms_o(dwell_ms_o),
        .dwell_valid_o(dwell_valid_o), .stuck_o(stuck_o), .state_o(state_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input bit enter, input int c, input int cnt, input int dwell);
        ev_t e;
        e.enter = enter; e.cyc = c; e.cnt = cnt; e.dwell = dwell;
        sb.push_back(e);
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_enter"}, int'(enter_o), 0);
        check({tag, "_leave"}, int'(leave_o), 0);
        check({tag, "_dv"}, int'(dwell_valid_o), 0);
        check({tag, "_stuck"}, int'(stuck_o), 0);
        check({tag, "_count"}, int'(count_o), 0);
        check({tag, "_dwell"}, int'(dwell_ms_o), 0);
        check({tag, "_state"}, int'(state_o), 0);
    endtask
    // object held high for n sampled edges; clr raises clear_i on the accepting edge
    task automatic pass_obj(input int n, input int cnt, input int dwell, input bit clr);
        int e0;
        e0 = cyc + 1;
        push(1'b1, e0 + ENTER_LAT, cnt, 0);
        object_i = 1'b1;
        if (clr) begin
            hold(ENTER_LAT);
            clear_i = 1'b1;
            hold(1);
            clear_i = 1'b0;
            hold(n - ENTER_LAT - 1);
        end else hold(n);
        push(1'b0, e0 + n, cnt, dwell);
        object_i = 1'b0;
        hold(3);
    endtask
    always @(negedge clk)
        if (rst && (enter_o || leave_o || dwell_valid_o)) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_event: enter=%b leave=%b dv=%b count=%0d cyc=%0d",
                         enter_o, leave_o, dwell_valid_o, count_o, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_enter", int'(enter_o), int'(e.enter));
                check("ev_leave", int'(leave_o), int'(!e.enter));
                check("ev_dv", int'(dwell_valid_o), int'(!e.enter));
                check("ev_cycle", cyc, e.cyc);
                check("ev_count", int'(count_o), e.cnt);
                if (!e.enter) begin
                    check("ev_dwell", int'(dwell_ms_o), e.dwell);
                    check("ev_stuck", int'(stuck_o), 0);
                end
            end
        end
    initial begin
        int e0;
        rst = 1'b0;
        object_i = 1'b0;
        clear_i = 1'b0;
        #2 check_all_zero("reset");
        hold(2);
        rst = 1'b1;
        hold(2);
        object_i = 1'b1;
        hold(10);
        object_i = 1'b0;
        hold(2);
        check("glitch_state", int'(state_o), 0);
        check("glitch_count", int'(count_o), 0);
        pass_obj(30, 1, 7, 1'b0);
        e0 = cyc + 1;
        push(1'b1, e0 + ENTER_LAT, 2, 0);
        object_i = 1'b1;
        hold(41);
        check("stuck_before", int'(stuck_o), 0);
        hold(1);
        check("stuck_rise", int'(stuck_o), 1);
        check("stuck_state", int'(state_o), 3);
        hold(18);
        push(1'b0, e0 + 60, 2, MAX_DWELL_MS);
        object_i = 1'b0;
        hold(3);
        check("stuck_clear", int'(stuck_o), 0);
        check("stuck_idle", int'(state_o), 0);
        pass_obj(15, 0, 3, 1'b1);
        pass_obj(16, 1, 3, 1'b0);
        e0 = cyc + 1;
        push(1'b1, e0 + ENTER_LAT, 2, 0);
        object_i = 1'b1;
        hold(20);
        check("pre_reset_state", int'(state_o), 2);
        rst = 1'b0;
        #1 check_all_zero("async_reset");
        hold(2);
        rst = 1'b1;
        e0 = cyc + 1;
        push(1'b1, e0 + ENTER_LAT, 1, 0);
        hold(16);
        push(1'b0, e0 + 16, 1, 3);
        object_i = 1'b0;
        hold(3);
        pass_obj(14, 2, 3, 1'b0);
        for (int i = 0; i < 4; i++) pass_obj(14, 3, 3, 1'b0);
        check("sat_count", int'(count_o), 3);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
